// File: rtl/sag4fun_pkg.sv
// Shared types and helpers for the SAG4Fun sequential-engine front end:
// FSM state encoding, engine latency per datapath width, requester-index width.
package sag4fun_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_GO,
    LOAD_WAIT,
    OP_GO,
    OP_WAIT,
    RESP
  } state_t;

  function automatic int sag_lat(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sag4fun_seq_ctrl_if.sv
// Request/response bus and engine-control bundle of the SAG4Fun controller.
// master = core issue logic plus engine side, slave = the controller.
interface sag4fun_seq_ctrl_if
  import sag4fun_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) ();

  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ*XLEN-1:0] req_mask;
  logic [NREQ-1:0]      req_inv;
  logic [NREQ-1:0]      req_msk;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_data;
  logic                 rsp_hit;
  logic                 busy;
  logic                 sag_reset;
  logic                 sag_start;
  logic                 sag_inv;
  logic                 sag_msk;
  logic                 sag_ldm;
  logic [XLEN-1:0]      sag_in_data;
  logic                 sag_ready;
  logic [XLEN-1:0]      sag_out_data;

  modport master (
    output req_valid, req_data, req_mask, req_inv, req_msk, rsp_ready,
           sag_ready, sag_out_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, busy,
           sag_reset, sag_start, sag_inv, sag_msk, sag_ldm, sag_in_data
  );

  modport slave (
    input  req_valid, req_data, req_mask, req_inv, req_msk, rsp_ready,
           sag_ready, sag_out_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, busy,
           sag_reset, sag_start, sag_inv, sag_msk, sag_ldm, sag_in_data
  );

endinterface

// File: rtl/sag4fun_rr_arb.sv
// NREQ-wide round-robin arbiter: one-hot grant, priority pointer moves past
// the granted requester only when the accept strobe is high.
module sag4fun_rr_arb
  import sag4fun_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        i_req,
  input  logic                   i_accept,
  output logic [NREQ-1:0]        o_grant,
  output logic [idw(NREQ)-1:0]   o_idx
);

  localparam int IDW = idw(NREQ);

  logic [IDW-1:0] r_ptr;

  // Scan from lowest to highest priority so the requester nearest the pointer wins.
  always_comb begin
    int w_pos;
    w_pos   = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = (int'(r_ptr) + k) % NREQ;
      if (i_req[w_pos]) begin
        o_grant = NREQ'(1) << w_pos;
        o_idx   = IDW'(w_pos);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= IDW'((int'(o_idx) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/sag4fun_seq_ctrl.sv
// Arbitrating front end for one shared sequential SAG4Fun engine: skips the
// mask-load pass on a cached mask (SAG4FUN_MASKCACHE_EN) and applies msk zeroing.
module sag4fun_seq_ctrl
  import sag4fun_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) (
  input  logic            clock,
  input  logic            resetn,
  sag4fun_seq_ctrl_if.slave bus
);

  localparam int IDW = idw(NREQ);

  state_t          r_state;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_accept;
  logic            w_hit;
  logic [XLEN-1:0] w_sel_data;
  logic [XLEN-1:0] w_sel_mask;
  logic            w_sel_inv;
  logic            w_sel_msk;

  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_mask;
  logic            r_inv;
  logic            r_msk;
  logic            r_hit;

  logic            r_busy;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_hit;
  logic            r_sag_start;
  logic            r_sag_ldm;
  logic            r_sag_inv;
  logic            r_sag_msk;
  logic [XLEN-1:0] r_sag_in_data;

  // The engine only compresses/expands; zeroing outside the mask happens here,
  // on the operand for compress and on the result for expand.
  function automatic logic [XLEN-1:0] op_operand(input logic [XLEN-1:0] d,
                                                 input logic [XLEN-1:0] m,
                                                 input logic inv, input logic msk);
    return (msk && !inv) ? (d & m) : d;
  endfunction

  function automatic logic [XLEN-1:0] op_result(input logic [XLEN-1:0] o,
                                                input logic [XLEN-1:0] m,
                                                input logic inv, input logic msk);
    return (msk && inv) ? (o & m) : o;
  endfunction

  sag4fun_rr_arb #(.NREQ(NREQ)) u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .i_req    (bus.req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_gnt_idx)
  );

  assign w_accept   = resetn && (r_state == IDLE) && (|bus.req_valid);
  assign w_sel_data = bus.req_data[int'(w_gnt_idx)*XLEN +: XLEN];
  assign w_sel_mask = bus.req_mask[int'(w_gnt_idx)*XLEN +: XLEN];
  assign w_sel_inv  = bus.req_inv[w_gnt_idx];
  assign w_sel_msk  = bus.req_msk[w_gnt_idx];

`ifdef SAG4FUN_MASKCACHE_EN
  logic            r_cache_valid;
  logic [XLEN-1:0] r_cache_mask;

  // Mirrors the engine's swap-config store; one entry serves both directions.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cache_valid <= 1'b0;
    end else if (r_state == LOAD_GO) begin
      r_cache_valid <= 1'b1;
      r_cache_mask  <= r_mask;
    end
  end

  assign w_hit = r_cache_valid && (r_cache_mask == w_sel_mask);
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_data <= w_sel_data;
      r_mask <= w_sel_mask;
      r_inv  <= w_sel_inv;
      r_msk  <= w_sel_msk;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_hit         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_rsp_hit     <= 1'b0;
      r_sag_start   <= 1'b0;
      r_sag_ldm     <= 1'b0;
      r_sag_inv     <= 1'b0;
      r_sag_msk     <= 1'b0;
      r_sag_in_data <= '0;
    end else begin
      r_sag_start   <= 1'b0;
      r_sag_ldm     <= 1'b0;
      r_sag_inv     <= 1'b0;
      r_sag_msk     <= 1'b0;
      r_sag_in_data <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy      <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_hit       <= w_hit;
            r_sag_start <= 1'b1;
            if (w_hit) begin
              r_state       <= OP_GO;
              r_sag_inv     <= w_sel_inv;
              r_sag_msk     <= w_sel_msk;
              r_sag_in_data <= op_operand(w_sel_data, w_sel_mask, w_sel_inv, w_sel_msk);
            end else begin
              r_state       <= LOAD_GO;
              r_sag_ldm     <= 1'b1;
              r_sag_in_data <= w_sel_mask;
            end
          end
        end
        LOAD_GO: r_state <= LOAD_WAIT;
        LOAD_WAIT: begin
          if (bus.sag_ready) begin
            r_state       <= OP_GO;
            r_sag_start   <= 1'b1;
            r_sag_inv     <= r_inv;
            r_sag_msk     <= r_msk;
            r_sag_in_data <= op_operand(r_data, r_mask, r_inv, r_msk);
          end
        end
        OP_GO: r_state <= OP_WAIT;
        OP_WAIT: begin
          if (bus.sag_ready) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= op_result(bus.sag_out_data, r_mask, r_inv, r_msk);
            r_rsp_hit   <= r_hit;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_accept ? w_grant : '0;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.busy        = r_busy;
  assign bus.sag_reset   = !resetn;
  assign bus.sag_start   = r_sag_start;
  assign bus.sag_ldm     = r_sag_ldm;
  assign bus.sag_inv     = r_sag_inv;
  assign bus.sag_msk     = r_sag_msk;
  assign bus.sag_in_data = r_sag_in_data;

endmodule

// File: tb/tb_sag4fun_seq_ctrl.sv
// Scoreboard bench for sag4fun_seq_ctrl (XLEN=64, NREQ=2) with a behavioural
// sequential SAG engine; expectations adapt to SAG4FUN_MASKCACHE_EN.
module tb_sag4fun_seq_ctrl;
  import sag4fun_pkg::*;

  localparam int XLEN = 64;
  localparam int NREQ = 2;
  localparam int LAT  = sag_lat(XLEN);
  localparam logic [63:0] JUNK = 64'hBAD0_F00D_BAD0_F00D;
`ifdef SAG4FUN_MASKCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [63:0] data;
    logic        hit;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  int   acc_cycle = 0;
  int   acc_cnt = 0;
  int   ldm_cnt = 0;
  int   ldm_cyc = 0;
  int   last_hs = 0;

  sag4fun_seq_ctrl_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  sag4fun_seq_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] sag_shuf(input logic [63:0] d, input logic [63:0] m);
    logic [63:0] r;
    int j;
    r = '0; j = 0;
    for (int i = 0; i < 64; i++) if (m[i])  begin r[j] = d[i]; j++; end
    for (int i = 0; i < 64; i++) if (!m[i]) begin r[j] = d[i]; j++; end
    return r;
  endfunction

  function automatic logic [63:0] sag_unshuf(input logic [63:0] d, input logic [63:0] m);
    logic [63:0] r;
    int j;
    r = '0; j = 0;
    for (int i = 0; i < 64; i++) if (m[i])  begin r[i] = d[j]; j++; end
    for (int i = 0; i < 64; i++) if (!m[i]) begin r[i] = d[j]; j++; end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Behavioural engine: ldm loads the swap config, data passes use it, LAT cycles.
  int          eng_cnt;
  logic [63:0] eng_cfg;
  logic [63:0] eng_res;
  always @(posedge clock) begin
    if (bus.sag_reset) begin
      eng_cnt          <= 0;
      eng_cfg          <= '0;
      bus.sag_ready    <= 1'b0;
      bus.sag_out_data <= JUNK;
    end else begin
      bus.sag_ready    <= 1'b0;
      bus.sag_out_data <= JUNK;
      if (bus.sag_start) begin
        eng_cnt <= LAT - 1;
        if (bus.sag_ldm) eng_cfg <= bus.sag_in_data;
        else eng_res <= bus.sag_inv ? sag_unshuf(bus.sag_in_data, eng_cfg)
                                    : sag_shuf(bus.sag_in_data, eng_cfg);
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          bus.sag_ready    <= 1'b1;
          bus.sag_out_data <= eng_res;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        chk("req_ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
        acc_cycle = cyc;
        acc_cnt++;
        ldm_cnt = 0;
      end
      if (bus.sag_start && bus.sag_ldm) begin
        ldm_cnt++;
        ldm_cyc = cyc;
      end
    end
  end

  logic        prev_v = 1'b0;
  logic [63:0] hold_data;
  logic        hold_id;
  logic        hold_hit;
  always @(negedge clock) begin
    if (!resetn) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          bad("unexpected_rsp");
        end else begin
          chk("latency", 64'(cyc - acc_cycle), 64'(sb[0].lat));
          chk("ldm_passes", 64'(ldm_cnt), sb[0].hit ? 64'd0 : 64'd1);
          if (!sb[0].hit) chk("ldm_cycle", 64'(ldm_cyc - acc_cycle), 64'd1);
        end
        hold_data = bus.rsp_data;
        hold_id   = bus.rsp_id;
        hold_hit  = bus.rsp_hit;
      end else if (bus.rsp_valid) begin
        chk("hold_data", bus.rsp_data, hold_data);
        chk("hold_id", 64'(bus.rsp_id), 64'(hold_id));
        chk("hold_hit", 64'(bus.rsp_hit), 64'(hold_hit));
      end
      if (bus.rsp_valid) chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_hs = cyc;
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_hit", 64'(bus.rsp_hit), 64'(e.hit));
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic push_exp(input int id, input logic [63:0] d, input logic hit);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.hit  = hit & CACHE;
    e.lat  = e.hit ? 8 : 15;
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [63:0] d, input logic [63:0] m,
                         input logic inv, input logic msk);
    @(posedge clock); #1;
    bus.req_data[id*64 +: 64] = d;
    bus.req_mask[id*64 +: 64] = m;
    bus.req_inv[id]   = inv;
    bus.req_msk[id]   = msk;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic issue(input int id, input logic [63:0] d, input logic [63:0] m,
                       input logic inv, input logic msk);
    int t;
    set_req(id, d, m, inv, msk);
    t = 0;
    @(negedge clock);
    while (!bus.req_ready[id] && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!bus.req_ready[id]) bad("accept_timeout");
    @(posedge clock); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && t < 300) begin
      @(posedge clock);
      t++;
    end
    if (sb.size() != 0 || bus.rsp_valid) bad("drain_timeout");
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_mask  = '0;
    bus.req_inv   = '0;
    bus.req_msk   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1 bus.req_valid = 2'b11;
    @(posedge clock); #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sag_reset", 64'(bus.sag_reset), 64'd1);
    chk("rst_sag_ctl", 64'({bus.sag_start, bus.sag_ldm, bus.sag_inv, bus.sag_msk}), 64'd0);
    chk("rst_sag_in_data", bus.sag_in_data, 64'd0);
    bus.req_valid = '0;
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_sag_reset", 64'(bus.sag_reset), 64'd0);

    // First request after reset: miss, compress with msk.
    push_exp(0, 64'h0000_0000_0000_0DE0, 1'b0);
    issue(0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_FF0F, 1'b0, 1'b1);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
    drain();

    // Same mask from requester 1, expand with msk: cached.
    push_exp(1, 64'h0000_0000_0000_DE00, 1'b1);
    issue(1, 64'h0000_0000_0000_0DE0, 64'h0000_0000_0000_FF0F, 1'b1, 1'b1);
    drain();

    // Both requesters continuously valid with distinct masks.
    push_exp(0, 64'h0000_0000_0000_3333, 1'b0);
    push_exp(1, 64'hAB00_0000_0000_0000, 1'b0);
    push_exp(0, 64'h0000_0000_0000_3333, 1'b0);
    push_exp(1, 64'hAB00_0000_0000_0000, 1'b0);
    base = acc_cnt;
    set_req(0, 64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_0000, 1'b0, 1'b1);
    bus.req_data[64 +: 64] = 64'h0000_0000_0000_00AB;
    bus.req_mask[64 +: 64] = 64'hFF00_0000_0000_0000;
    bus.req_inv[1]   = 1'b1;
    bus.req_msk[1]   = 1'b1;
    bus.req_valid[1] = 1'b1;
    t = 0;
    while (acc_cnt < base + 4 && t < 400) begin
      @(posedge clock);
      t++;
    end
    if (acc_cnt < base + 4) bad("arb_accept_timeout");
    #1 bus.req_valid = '0;
    drain();

    // Response back-pressure, with a second requester waiting.
    @(posedge clock); #1 bus.rsp_ready = 1'b0;
    push_exp(0, 64'h0000_0000_0000_005A, 1'b0);
    issue(0, 64'h0000_0000_0000_00A5, 64'h0000_0000_0000_00F0, 1'b0, 1'b0);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      @(posedge clock);
      t++;
    end
    if (!bus.rsp_valid) bad("rsp_timeout");
    push_exp(1, 64'h0000_0000_0000_00A5, 1'b1);
    base = acc_cnt;
    set_req(1, 64'h0000_0000_0000_005A, 64'h0000_0000_0000_00F0, 1'b1, 1'b0);
    repeat (10) @(posedge clock);
    #1 bus.rsp_ready = 1'b1;
    t = 0;
    while (acc_cnt == base && t < 50) begin
      @(posedge clock);
      t++;
    end
    if (acc_cnt == base) bad("accept_after_hs_timeout");
    else chk("accept_after_hs", 64'(acc_cycle), 64'(last_hs + 1));
    #1 bus.req_valid = '0;
    drain();

    // Reset while the data pass is in flight: no response, cache forgotten.
    set_req(0, 64'h0000_0000_0000_00A5, 64'h0000_0000_0000_00F0, 1'b0, 1'b0);
    t = 0;
    @(negedge clock);
    while (!(bus.sag_start && !bus.sag_ldm) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!(bus.sag_start && !bus.sag_ldm)) bad("op_go_timeout");
    @(posedge clock); #1;
    bus.req_valid = '0;
    resetn = 1'b0;
    #1 chk("mid_rst_sag_reset", 64'(bus.sag_reset), 64'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    resetn = 1'b1;
    repeat (LAT + 8) @(posedge clock);
    push_exp(0, 64'h0000_0000_0000_005A, 1'b0);
    issue(0, 64'h0000_0000_0000_00A5, 64'h0000_0000_0000_00F0, 1'b0, 1'b0);
    drain();

    // Same mask twice in a row from one requester.
    push_exp(1, 64'h0000_0000_0000_3333, 1'b0);
    issue(1, 64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_0000, 1'b0, 1'b1);
    drain();
    push_exp(1, 64'h0000_0000_0000_3333, 1'b1);
    issue(1, 64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_0000, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sag4fun_seq_ctrl.md
# sag4fun_seq_ctrl

Front-end controller and arbiter that shares one sequential SAG4Fun engine (32- or 64-bit iterative variant) among NREQ requesters. It accepts compress/expand requests over valid/ready, round-robin arbitrates between requesters, and issues a mask-load pass (ldm) only when the requested mask differs from the mask currently held in the engine's swap-config store. It then runs the data pass, applies the msk zeroing the sequential engine does not perform, and returns a tagged response. It sits between the core's bit-manipulation issue logic and the engine instance.

## Interface
- XLEN, 64: datapath width; only 32 and 64 are legal.
- NREQ, 2: number of requesters, 2..4.
- LAT, XLEN==64 ? 6 : 5: engine cycles from start to ready pulse.
- clock  in  1  rising-edge clock; the only clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_data  in  NREQ*XLEN  operand; requester i at [i*XLEN +: XLEN].
- req_mask  in  NREQ*XLEN  mask operand, same packing.
- req_inv  in  NREQ  1 = expand (unshuffle), 0 = compress.
- req_msk  in  NREQ  1 = zero bits outside the mask.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  index of the requester served.
- rsp_data  out  XLEN  result.
- rsp_hit  out  1  1 = the mask load was skipped.
- busy  out  1  FSM not in IDLE.
- sag_reset  out  1  active-high engine reset, equal to !resetn.
- sag_start, sag_inv, sag_msk, sag_ldm  out  1 each  engine control.
- sag_in_data  out  XLEN  engine operand.
- sag_ready  in  1  engine one-cycle done pulse.
- sag_out_data  in  XLEN  engine result; valid only while sag_ready is high.

## Operation
- FSM states: IDLE, LOAD_GO, LOAD_WAIT, OP_GO, OP_WAIT, RESP.
- IDLE
  - req_ready = rr_grant(req_valid) when any request is valid.
  - On handshake, latch data, mask, inv, msk and id.
  - Go to OP_GO if cache_valid && cache_mask == mask. Otherwise go to LOAD_GO.
- LOAD_GO
  - One cycle with sag_start=1, sag_ldm=1, sag_inv=0, sag_msk=0, sag_in_data=mask.
  - Update cache_mask=mask and cache_valid=1. Go to LOAD_WAIT.
- LOAD_WAIT: on sag_ready, go to OP_GO.
- OP_GO
  - One cycle with sag_start=1, sag_ldm=0, sag_inv=inv, sag_msk=msk.
  - sag_in_data = (msk && !inv) ? data & mask : data.
- OP_WAIT
  - On sag_ready, capture rsp_data = (msk && inv) ? sag_out_data & mask : sag_out_data.
  - Set rsp_hit per the IDLE decision. Go to RESP.
- RESP
  - rsp_valid=1. Hold rsp_data, rsp_id and rsp_hit stable until rsp_ready.
  - On rsp_valid && rsp_ready, return to IDLE.
- Round-robin arbitration
  - The priority pointer moves to (granted+1) mod NREQ on each accept only.
  - The pointer resets to 0.
- Control outputs outside the GO states: sag_start=0. sag_ldm, sag_inv, sag_msk and sag_in_data are 0.
- A cached mask serves both inv=0 and inv=1 requests. The load pass always runs with inv=0.
- A sag_ready pulse in IDLE, LOAD_GO, OP_GO or RESP is ignored.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_hit=0, busy=0, sag_start=0, all sag_* controls and sag_in_data=0.
- On reset: FSM to IDLE, cache_valid=0, pointer=0.
- Reset asserted mid-operation aborts the request with no response. sag_reset resets the engine in the same cycle.
- Accept in cycle 0:
  - Miss: LOAD_GO in cycle 1, sag_ready in cycle 1+LAT, OP_GO in cycle 2+LAT, sag_ready in cycle 2+2LAT, rsp_valid from cycle 3+2LAT.
  - Hit: OP_GO in cycle 1, rsp_valid from cycle 2+LAT.
- Latency for XLEN=64: hit 8 cycles, miss 15 cycles.
- No new request is accepted until the cycle after the response handshake. req_ready is 0 in every non-IDLE state.

## Configuration
- SAG4FUN_MASKCACHE_EN defined: cache compare as above; rsp_hit can be 1.
- SAG4FUN_MASKCACHE_EN undefined:
  - Every request takes the LOAD_GO path; rsp_hit is tied to 0.
  - The cache_mask register is not built.

## Structure
- Shared package sag4fun_pkg holds:
  - the FSM state enum;
  - the function returning LAT from XLEN;
  - the IDW = $clog2(NREQ) helper.
- One sub-module: sag4fun_rr_arb (NREQ-wide round-robin, one-hot grant, pointer advanced by an accept strobe).
- The engine instance is outside this block and connects through the sag_* ports.

## Test plan
- XLEN=64, requester 0: mask=0x00000000_0000FF0F, data=0x12345678_9ABCDEF0, inv=0, msk=1, first request after reset.
  - Required: sag_ldm pulse in cycle 1, rsp_hit=0, rsp_valid in cycle 15, rsp_id=0.
  - rsp_data must equal the reference compress of data under mask with bits outside the mask zeroed.
- Same mask again from requester 1 with inv=1.
  - Required: no ldm pass, rsp_hit=1, rsp_valid in cycle 8, rsp_id=1.
- Both requesters valid continuously with distinct masks.
  - Required: grants alternate 0,1,0,1; every request misses; 4 responses in order.
- rsp_ready held low for 10 cycles in RESP.
  - Required: rsp_* stable; req_ready=0 throughout; next accept in the cycle after the handshake.
- resetn low in OP_WAIT, then a repeat of the previous mask.
  - Required: no response for the aborted request; the repeat misses (cache_valid cleared).
- Build without SAG4FUN_MASKCACHE_EN and repeat the mask twice.
  - Required: both requests take 15 cycles; rsp_hit=0 on both.
